// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: decoded control flags, the bubble control
// value and the hardwired-zero register specifier.
package pipe_pkg;

  // Single-bit decoded control flags. The ALU op is carried beside this
  // struct because its width is a module parameter.
  typedef struct packed {
    logic jump;
    logic branch;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regdst;
    logic regwrite;
    logic alusrc;
  } ctrl_flags_t;

  // A bubble carries no side effects: no register write, no memory access.
  localparam ctrl_flags_t BUBBLE_FLAGS = '0;

  // Register 0 is hardwired to zero, so a load targeting it never creates a
  // true data dependence.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose
// destination is read by the instruction currently in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic              id_branch,
  output logic              hazard
);

  logic uses_rt;
  logic rt_nonzero;

  // rt is a source unless it is replaced by the immediate; stores and
  // branches read it regardless of alusrc.
  assign uses_rt    = ~id_alusrc | id_memwrite | id_branch;
  assign rt_nonzero = (ex_rt != REG_AW'(REG_ZERO));

  assign hazard = ex_valid & ex_memread & rt_nonzero & id_valid &
                  ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush/hold handling and a
// saturating count of inserted bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_jump,
  input  logic               id_branch,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               id_regdst,
  input  logic               id_regwrite,
  input  logic               id_alusrc,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               ex_valid,
  output logic               ex_jump,
  output logic               ex_branch,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_regdst,
  output logic               ex_regwrite,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_flags_t id_flags;
  logic        hazard;

  logic               ex_valid_d,   ex_valid_q;
  ctrl_flags_t        ex_flags_d,   ex_flags_q;
  logic [ALUOP_W-1:0] ex_aluop_d,   ex_aluop_q;
  logic [DATA_W-1:0]  ex_pc4_d,     ex_pc4_q;
  logic [DATA_W-1:0]  ex_rs_data_d, ex_rs_data_q;
  logic [DATA_W-1:0]  ex_rt_data_d, ex_rt_data_q;
  logic [DATA_W-1:0]  ex_imm_d,     ex_imm_q;
  logic [REG_AW-1:0]  ex_rs_d,      ex_rs_q;
  logic [REG_AW-1:0]  ex_rt_d,      ex_rt_q;
  logic [REG_AW-1:0]  ex_rd_d,      ex_rd_q;
  logic [CNT_W-1:0]   bubble_cnt_d, bubble_cnt_q;
  logic               bubble_inc;

  assign id_flags = '{jump:     id_jump,
                      branch:   id_branch,
                      memread:  id_memread,
                      memwrite: id_memwrite,
                      memtoreg: id_memtoreg,
                      regdst:   id_regdst,
                      regwrite: id_regwrite,
                      alusrc:   id_alusrc};

  load_use_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_memread  (ex_flags_q.memread),
    .ex_rt       (ex_rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_alusrc   (id_alusrc),
    .id_memwrite (id_memwrite),
    .id_branch   (id_branch),
    .hazard      (hazard)
  );

  // A taken redirect must let IF fetch the new target, so flush masks stall.
  assign stall = ~flush & (ex_hold | hazard);

  // Next-state selection: flush > hold > hazard > normal capture.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_flags_d   = ex_flags_q;
    ex_aluop_d   = ex_aluop_q;
    ex_pc4_d     = ex_pc4_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    bubble_inc   = 1'b0;
    if (flush || (!ex_hold && hazard)) begin
      ex_valid_d   = 1'b0;
      ex_flags_d   = BUBBLE_FLAGS;
      ex_aluop_d   = '0;
      ex_pc4_d     = '0;
      ex_rs_data_d = '0;
      ex_rt_data_d = '0;
      ex_imm_d     = '0;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_rd_d      = '0;
      // A squashed empty slot is not a lost instruction, so it is not counted.
      bubble_inc   = flush ? id_valid : 1'b1;
    end else if (!ex_hold) begin
      ex_valid_d   = id_valid;
      ex_flags_d   = id_flags;
      ex_aluop_d   = id_aluop;
      ex_pc4_d     = id_pc4;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
    end
  end

  // Saturating bubble counter.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_flags_q   <= BUBBLE_FLAGS;
      ex_aluop_q   <= '0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_flags_q   <= ex_flags_d;
      ex_aluop_q   <= ex_aluop_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_jump     = ex_flags_q.jump;
  assign ex_branch   = ex_flags_q.branch;
  assign ex_memread  = ex_flags_q.memread;
  assign ex_memwrite = ex_flags_q.memwrite;
  assign ex_memtoreg = ex_flags_q.memtoreg;
  assign ex_regdst   = ex_flags_q.regdst;
  assign ex_regwrite = ex_flags_q.regwrite;
  assign ex_alusrc   = ex_flags_q.alusrc;
  assign ex_aluop    = ex_aluop_q;
  assign ex_pc4      = ex_pc4_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with a queue-based scoreboard.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        jump, branch, memread, memwrite, memtoreg, regdst, regwrite, alusrc;
    logic [5:0]  aluop;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } out_t;

  typedef struct packed {
    logic rst, flush, hold;
    out_t f;
  } in_t;

  typedef struct {
    string       name;
    logic        stall;
    out_t        ex;
    logic [15:0] cnt;
  } exp_t;

  // flag order: jump branch memread memwrite memtoreg regdst regwrite alusrc
  localparam logic [7:0] F_ADD  = 8'b0000_0110;
  localparam logic [7:0] F_LW   = 8'b0010_1011;
  localparam logic [7:0] F_SW   = 8'b0001_0001;
  localparam logic [7:0] F_ADDI = 8'b0000_0011;

  logic        clk, rst, id_valid, flush, ex_hold;
  logic        id_jump, id_branch, id_memread, id_memwrite, id_memtoreg, id_regdst, id_regwrite, id_alusrc;
  logic [5:0]  id_aluop;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid, ex_jump, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc;
  logic [5:0]  ex_aluop;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall;
  logic [15:0] bubble_cnt;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_jump(id_jump), .id_branch(id_branch), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regdst(ex_regdst),
    .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t instr(input logic [7:0] fl, input logic [5:0] op,
                                 input logic [4:0] rs_i, input logic [4:0] rt_i,
                                 input logic [4:0] rd_i, input logic [31:0] seed);
    out_t o;
    o.valid = 1'b1;
    {o.jump, o.branch, o.memread, o.memwrite, o.memtoreg, o.regdst, o.regwrite, o.alusrc} = fl;
    o.aluop = op;
    o.pc4   = seed;
    o.rsd   = seed ^ 32'h1111_0000;
    o.rtd   = seed + 32'h77;
    o.imm   = {16'hFFFF, seed[15:0]};
    o.rs    = rs_i;
    o.rt    = rt_i;
    o.rd    = rd_i;
    return o;
  endfunction

  function automatic in_t mk(input out_t f, input logic r, input logic fl, input logic h);
    in_t v;
    v.rst = r; v.flush = fl; v.hold = h; v.f = f;
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; flush = v.flush; ex_hold = v.hold;
    id_valid = v.f.valid;
    {id_jump, id_branch, id_memread, id_memwrite, id_memtoreg, id_regdst, id_regwrite, id_alusrc} =
      {v.f.jump, v.f.branch, v.f.memread, v.f.memwrite, v.f.memtoreg, v.f.regdst, v.f.regwrite, v.f.alusrc};
    id_aluop = v.f.aluop; id_pc4 = v.f.pc4; id_rs_data = v.f.rsd; id_rt_data = v.f.rtd;
    id_imm = v.f.imm; id_rs = v.f.rs; id_rt = v.f.rt; id_rd = v.f.rd;
  endtask

  // Present inputs for one cycle and queue what must be seen for it.
  task automatic step(input string nm, input in_t v, input logic es, input out_t ee, input logic [15:0] ec);
    exp_t e;
    @(posedge clk); #2;
    drive(v);
    e.name = nm; e.stall = es; e.ex = ee; e.cnt = ec;
    sbq.push_back(e);
  endtask

  // Monitor: stall is checked mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (stall !== e.stall) begin
          n_bad++;
          $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
        end
        @(posedge clk); #1;
        a.valid = ex_valid;
        {a.jump, a.branch, a.memread, a.memwrite, a.memtoreg, a.regdst, a.regwrite, a.alusrc} =
          {ex_jump, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc};
        a.aluop = ex_aluop; a.pc4 = ex_pc4; a.rsd = ex_rs_data; a.rtd = ex_rt_data;
        a.imm = ex_imm; a.rs = ex_rs; a.rt = ex_rt; a.rd = ex_rd;
        n_cmp++;
        if (a !== e.ex) begin
          n_bad++;
          $display("FAIL %s ex_regs: got %h want %h", e.name, a, e.ex);
        end
        n_cmp++;
        if (bubble_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s bubble_cnt: got %h want %h", e.name, bubble_cnt, e.cnt);
        end
      end
    end
  end

  out_t z, add1, lw5, add5, lw0, add0, lw7, addi7, sw7, lw9, add9, nv9, rnd;

  initial begin
    z     = '0;
    add1  = instr(F_ADD,  6'h02, 5'd1, 5'd2, 5'd3, 32'h0000_1004);
    lw5   = instr(F_LW,   6'h00, 5'd1, 5'd5, 5'd0, 32'h0000_1008);
    add5  = instr(F_ADD,  6'h02, 5'd5, 5'd2, 5'd6, 32'h0000_100C);
    lw0   = instr(F_LW,   6'h00, 5'd0, 5'd0, 5'd0, 32'h0000_1010);
    add0  = instr(F_ADD,  6'h02, 5'd0, 5'd0, 5'd8, 32'h0000_1014);
    lw7   = instr(F_LW,   6'h00, 5'd2, 5'd7, 5'd0, 32'h0000_1018);
    addi7 = instr(F_ADDI, 6'h08, 5'd4, 5'd7, 5'd0, 32'h0000_101C);
    sw7   = instr(F_SW,   6'h00, 5'd4, 5'd7, 5'd0, 32'h0000_1020);
    lw9   = instr(F_LW,   6'h00, 5'd3, 5'd9, 5'd0, 32'h0000_1024);
    add9  = instr(F_ADD,  6'h21, 5'd9, 5'd1, 5'd10, 32'h0000_1028);
    nv9   = instr(F_ADD,  6'h02, 5'd9, 5'd9, 5'd11, 32'h0000_102C);
    nv9.valid = 1'b0;
    rnd   = out_t'({$urandom, $urandom, $urandom, $urandom, $urandom});

    drive(mk(z, 1'b1, 1'b0, 1'b0));
    // reset with random ID contents
    step("reset",       mk(rnd,   1, 0, 0), 1'b0, z,     16'd0);
    step("add_flow",    mk(add1,  0, 0, 0), 1'b0, add1,  16'd0);
    step("lw5_in",      mk(lw5,   0, 0, 0), 1'b0, lw5,   16'd0);
    step("loaduse",     mk(add5,  0, 0, 0), 1'b1, z,     16'd1);
    step("after_stall", mk(add5,  0, 0, 0), 1'b0, add5,  16'd1);
    step("lw0_in",      mk(lw0,   0, 0, 0), 1'b0, lw0,   16'd1);
    step("rt_zero",     mk(add0,  0, 0, 0), 1'b0, add0,  16'd1);
    step("lw7_in",      mk(lw7,   0, 0, 0), 1'b0, lw7,   16'd1);
    step("addi_no_rt",  mk(addi7, 0, 0, 0), 1'b0, addi7, 16'd1);
    step("lw7_again",   mk(lw7,   0, 0, 0), 1'b0, lw7,   16'd1);
    step("sw_uses_rt",  mk(sw7,   0, 0, 0), 1'b1, z,     16'd2);
    step("sw_proceeds", mk(sw7,   0, 0, 0), 1'b0, sw7,   16'd2);
    step("lw9_in",      mk(lw9,   0, 0, 0), 1'b0, lw9,   16'd2);
    step("id_invalid",  mk(nv9,   0, 0, 0), 1'b0, nv9,   16'd2);
    step("lw9_b",       mk(lw9,   0, 0, 0), 1'b0, lw9,   16'd2);
    step("flush_haz",   mk(add9,  0, 1, 0), 1'b0, z,     16'd3);
    step("lw9_c",       mk(lw9,   0, 0, 0), 1'b0, lw9,   16'd3);
    for (int i = 0; i < 3; i++)
      step("hold_haz",  mk(add9,  0, 0, 1), 1'b1, lw9,   16'd3);
    step("haz_release", mk(add9,  0, 0, 0), 1'b1, z,     16'd4);
    step("add9_enter",  mk(add9,  0, 0, 0), 1'b0, add9,  16'd4);
    step("flush_empty", mk(nv9,   0, 1, 0), 1'b0, z,     16'd4);
    step("lw9_d",       mk(lw9,   0, 0, 0), 1'b0, lw9,   16'd4);
    step("rst_midstall",mk(add9,  1, 0, 0), 1'b1, z,     16'd0);
    step("post_rst",    mk(add9,  0, 0, 0), 1'b0, add9,  16'd0);

    // drive the counter to one below saturation without checking each cycle
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk); #2;
      drive(mk(add9, 0, 1, 0));
    end
    step("sat_reach",   mk(add9,  0, 1, 0), 1'b0, z,     16'hFFFF);
    step("sat_hold",    mk(add9,  0, 1, 0), 1'b0, z,     16'hFFFF);

    repeat (4) @(posedge clk);
    #5;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
